// File: rtl/hier_unit_arbiter_pkg.sv
// Shared types for the round-robin shared-unit arbiter: FSM state encoding and default sizing.
package hier_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int W_DEF       = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;
endpackage

// File: rtl/hier_unit_arbiter_if.sv
// Requester-side and unit-side signal bundle for hier_unit_arbiter.
interface hier_unit_arbiter_if
  import hier_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int W       = W_DEF
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [W-1:0]         resp_c;
  logic [W-1:0]         unit_a;
  logic [W-1:0]         unit_b;
  logic [W-1:0]         unit_c;
  logic                 busy;

  modport slave  (input  req, req_a, req_b, unit_c,
                  output gnt, resp_valid, resp_c, unit_a, unit_b, busy);
  modport master (output req, req_a, req_b,
                  input  gnt, resp_valid, resp_c, busy);
  modport unit   (input  unit_a, unit_b, output unit_c);
endinterface

// File: rtl/hier_unit_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PW-1:0]      idx,
  output logic               any
);
  int          j;
  logic [PW-1:0] jw;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    jw     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j  = (int'(ptr) + k) % NUM_REQ;
      jw = PW'(j);
      if (!any && req[jw]) begin
        any        = 1'b1;
        idx        = jw;
        onehot[jw] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hier_unit_arbiter.sv
// Round-robin arbiter sharing one combinational a,b->c unit among NUM_REQ requesters.
// Optional HIER_ARB_STATS_EN adds txn_cnt and last_winner outputs.
module hier_unit_arbiter
  import hier_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hier_unit_arbiter_if.slave   bus
`ifdef HIER_ARB_STATS_EN
  ,
  output logic [15:0]          txn_cnt,
  output logic [PW-1:0]        last_winner
`endif
);
  state_t             state, nxt;
  logic [PW-1:0]      ptr, win_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic [W-1:0]       c_q;
  logic               ld, smp, fin;

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pick_any) nxt = ISSUE;
      ISSUE:   nxt = CAPTURE;
      CAPTURE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ld       = (state == IDLE) && pick_any;
    smp      = (state == ISSUE);
    fin      = (state == CAPTURE);
    bus.busy = (state == ISSUE) || (state == CAPTURE);
  end

  // The unit is fed only during ISSUE, so its output is sampled at the end of ISSUE
  // and only presented on resp_c at the end of CAPTURE, when operands are already back at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gnt        <= '0;
      bus.resp_valid <= '0;
      bus.resp_c     <= '0;
      bus.unit_a     <= '0;
      bus.unit_b     <= '0;
      c_q            <= '0;
      ptr            <= '0;
      win_idx        <= '0;
    end else begin
      bus.resp_valid <= '0;
      if (ld) begin
        bus.gnt    <= pick_oh;
        win_idx    <= pick_idx;
        bus.unit_a <= bus.req_a[int'(pick_idx)*W +: W];
        bus.unit_b <= bus.req_b[int'(pick_idx)*W +: W];
      end
      if (smp) begin
        c_q        <= bus.unit_c;
        bus.unit_a <= '0;
        bus.unit_b <= '0;
      end
      if (fin) begin
        bus.resp_c     <= c_q;
        bus.resp_valid <= bus.gnt;
        bus.gnt        <= '0;
        ptr            <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

`ifdef HIER_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt     <= '0;
      last_winner <= '0;
    end else if (fin) begin
      if (txn_cnt != 16'hFFFF) txn_cnt <= txn_cnt + 16'd1;
      last_winner <= win_idx;
    end
  end
`endif
endmodule

// File: tb/tb_hier_unit_arbiter.sv
// Directed bench for hier_unit_arbiter, NUM_REQ=4, W=1, with an a^b stub unit.
module tb_hier_unit_arbiter;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  hier_unit_arbiter_if #(.NUM_REQ(4), .W(1)) bus ();
  assign bus.unit_c = bus.unit_a ^ bus.unit_b;

`ifdef HIER_ARB_STATS_EN
  logic [15:0] txn_cnt;
  logic [1:0]  last_winner;
`endif

  hier_unit_arbiter #(.NUM_REQ(4), .W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HIER_ARB_STATS_EN
    ,
    .txn_cnt     (txn_cnt),
    .last_winner (last_winner)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b1111; bus.req_a = 4'b1111; bus.req_b = 4'b0000;
    step(); step();
    vecs++; if (bus.gnt !== 4'b0000) begin errs++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
    vecs++; if (bus.resp_valid !== 4'b0000) begin errs++; $display("FAIL reset_resp_valid got=%b want=0000", bus.resp_valid); end
    vecs++; if (bus.unit_a !== 1'b0 || bus.unit_b !== 1'b0) begin errs++; $display("FAIL reset_unit_ab got=%b%b want=00", bus.unit_a, bus.unit_b); end
    vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    vecs++; if (bus.resp_c !== 1'b0) begin errs++; $display("FAIL reset_resp_c got=%b want=0", bus.resp_c); end
`ifdef HIER_ARB_STATS_EN
    vecs++; if (txn_cnt !== 16'd0 || last_winner !== 2'd0) begin errs++; $display("FAIL reset_stats got=%0d/%0d want=0/0", txn_cnt, last_winner); end
`endif
    bus.req = '0; bus.req_a = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    bus.req = 4'b0010; bus.req_a = 4'b0010; bus.req_b = 4'b0000;
    step();
    vecs++; if (bus.gnt !== 4'b0010) begin errs++; $display("FAIL single_gnt got=%b want=0010", bus.gnt); end
    vecs++; if (bus.unit_a !== 1'b1 || bus.unit_b !== 1'b0) begin errs++; $display("FAIL single_issue_ab got=%b%b want=10", bus.unit_a, bus.unit_b); end
    vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL single_busy got=%b want=1", bus.busy); end
    bus.req = 4'b0000; bus.req_a = 4'b0000;  // dropped mid-transaction, must still complete
    step();
    vecs++; if (bus.unit_a !== 1'b0 || bus.gnt !== 4'b0010 || bus.resp_valid !== 4'b0000) begin errs++; $display("FAIL single_capture got ua=%b gnt=%b rv=%b want 0/0010/0000", bus.unit_a, bus.gnt, bus.resp_valid); end
    step();
    vecs++; if (bus.resp_valid !== 4'b0010) begin errs++; $display("FAIL single_resp_valid got=%b want=0010", bus.resp_valid); end
    vecs++; if (bus.resp_c !== 1'b1) begin errs++; $display("FAIL single_resp_c got=%b want=1", bus.resp_c); end
    vecs++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin errs++; $display("FAIL single_idle got gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy); end
    step();
    vecs++; if (bus.resp_valid !== 4'b0000 || bus.resp_c !== 1'b1) begin errs++; $display("FAIL single_pulse_hold got rv=%b c=%b want 0000/1", bus.resp_valid, bus.resp_c); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_c;
    logic [3:0] exp_oh;
    int         e;
    exp_c = 4'b0110;  // a=0101 ^ b=0011 per requester
    do_reset();
    bus.req = 4'b1111; bus.req_a = 4'b0101; bus.req_b = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      e      = k % 4;
      exp_oh = 4'b0001 << e;
      step();
      vecs++; if (bus.gnt !== exp_oh || bus.resp_valid !== 4'b0000) begin errs++; $display("FAIL rr_gnt[%0d] got gnt=%b rv=%b want %b/0000", k, bus.gnt, bus.resp_valid, exp_oh); end
      step(); step();
      vecs++; if (bus.resp_valid !== exp_oh || bus.resp_c !== exp_c[e]) begin errs++; $display("FAIL rr_resp[%0d] got rv=%b c=%b want %b/%b", k, bus.resp_valid, bus.resp_c, exp_oh, exp_c[e]); end
    end
    bus.req = 4'b0000;
`ifdef HIER_ARB_STATS_EN
    vecs++; if (txn_cnt !== 16'd5) begin errs++; $display("FAIL stats_txn_cnt got=%0d want=5", txn_cnt); end
    vecs++; if (last_winner !== 2'd0) begin errs++; $display("FAIL stats_last_winner got=%0d want=0", last_winner); end
`endif
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b0100; bus.req_a = 4'b0100; bus.req_b = 4'b0000;
    step();
    vecs++; if (bus.gnt !== 4'b0100) begin errs++; $display("FAIL wrap_pre_gnt got=%b want=0100", bus.gnt); end
    bus.req = 4'b0000;
    step(); step();
    vecs++; if (bus.resp_valid !== 4'b0100 || bus.resp_c !== 1'b1) begin errs++; $display("FAIL wrap_pre_resp got rv=%b c=%b want 0100/1", bus.resp_valid, bus.resp_c); end
    bus.req = 4'b0001; bus.req_a = 4'b0001; bus.req_b = 4'b0001;
    step();
    vecs++; if (bus.gnt !== 4'b0001) begin errs++; $display("FAIL wrap_gnt0 got=%b want=0001", bus.gnt); end
    step(); step();
    vecs++; if (bus.resp_valid !== 4'b0001 || bus.resp_c !== 1'b0) begin errs++; $display("FAIL wrap_resp0 got rv=%b c=%b want 0001/0", bus.resp_valid, bus.resp_c); end
    bus.req = 4'b1001; bus.req_a = 4'b1000; bus.req_b = 4'b0000;
    step();
    vecs++; if (bus.gnt !== 4'b1000) begin errs++; $display("FAIL wrap_gnt3 got=%b want=1000", bus.gnt); end
    bus.req = 4'b0000;
    step(); step();
    vecs++; if (bus.resp_valid !== 4'b1000 || bus.resp_c !== 1'b1) begin errs++; $display("FAIL wrap_resp3 got rv=%b c=%b want 1000/1", bus.resp_valid, bus.resp_c); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.req = 4'b0100; bus.req_a = 4'b0100; bus.req_b = 4'b0000;
    step();
    vecs++; if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1) begin errs++; $display("FAIL mid_issue got gnt=%b busy=%b want 0100/1", bus.gnt, bus.busy); end
    rst_n = 1'b0;
    #1;
    vecs++; if (bus.gnt !== 4'b0000 || bus.unit_a !== 1'b0 || bus.busy !== 1'b0 || bus.resp_c !== 1'b0) begin errs++; $display("FAIL mid_async got gnt=%b ua=%b busy=%b c=%b want 0000/0/0/0", bus.gnt, bus.unit_a, bus.busy, bus.resp_c); end
    step(); step();
    vecs++; if (bus.resp_valid !== 4'b0000) begin errs++; $display("FAIL mid_no_resp got=%b want=0000", bus.resp_valid); end
    rst_n = 1'b1;
    step();
    vecs++; if (bus.gnt !== 4'b0100) begin errs++; $display("FAIL mid_after_gnt got=%b want=0100", bus.gnt); end
    bus.req = 4'b0000;
    step(); step();
    vecs++; if (bus.resp_valid !== 4'b0100 || bus.resp_c !== 1'b1) begin errs++; $display("FAIL mid_after_resp got rv=%b c=%b want 0100/1", bus.resp_valid, bus.resp_c); end
    step();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
